// File: rtl/writeback_unit_if.sv
`default_nettype none
// ============================================================================
//  Module      : writeback_unit_if
//  Description : Bundle of ALU result, load issue/return, decode query and
//                register-file write signals around the writeback unit.
//  Revision    : 1.0 - initial release
// ============================================================================
interface writeback_unit_if;
    // ALU result channel
    logic        alu_valid;
    logic [4:0]  alu_rd;
    logic [31:0] alu_data;
    logic        alu_ready;
    // Load issue notification from decode
    logic        ld_issue;
    logic [4:0]  ld_issue_rd;
    // Load return channel
    logic        ld_valid;
    logic [4:0]  ld_rd;
    logic [2:0]  ld_funct3;
    logic [1:0]  ld_addr;
    logic [31:0] ld_rdata;
    logic        ld_ready;
    // Decode hazard query
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd_q;
    logic        hazard;
    logic [31:0] busy;
    // Register-file write port
    logic        wb_write;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;

    // Pipeline / memory side that drives requests and consumes writes
    modport master (
        output alu_valid, alu_rd, alu_data,
        output ld_issue, ld_issue_rd,
        output ld_valid, ld_rd, ld_funct3, ld_addr, ld_rdata,
        output rs1, rs2, rd_q,
        input  alu_ready, ld_ready, hazard, busy,
        input  wb_write, wb_rd, wb_data
    );

    // Writeback unit side
    modport slave (
        input  alu_valid, alu_rd, alu_data,
        input  ld_issue, ld_issue_rd,
        input  ld_valid, ld_rd, ld_funct3, ld_addr, ld_rdata,
        input  rs1, rs2, rd_q,
        output alu_ready, ld_ready, hazard, busy,
        output wb_write, wb_rd, wb_data
    );
endinterface
`default_nettype wire

// File: rtl/writeback_unit.sv
`default_nettype none
// ============================================================================
//  Module      : writeback_unit
//  Description : Merges ALU results and aligned load returns into a single
//                register-file write port. Loads are buffered in a 2-entry
//                FIFO and take priority over the ALU. A busy mask tracks
//                outstanding loads and raises a decode hazard.
//  Revision    : 1.0 - initial release
// ============================================================================
module writeback_unit (
    input  wire logic         clk,
    input  wire logic         rst,
    writeback_unit_if.slave   bus
);

    localparam logic [1:0] c_FIFO_FULL  = 2'd2;
    localparam logic [1:0] c_FIFO_EMPTY = 2'd0;

    // FIFO storage and bookkeeping
    logic [4:0]  r_fifo_rd   [0:1];
    logic [31:0] r_fifo_data [0:1];
    logic        r_rd_ptr;
    logic        r_wr_ptr;
    logic [1:0]  r_count;

    // Writeback and scoreboard state
    logic        r_wb_write;
    logic [4:0]  r_wb_rd;
    logic [31:0] r_wb_data;
    logic [31:0] r_busy;

    logic        w_full;
    logic        w_empty;
    logic        w_push;
    logic        w_pop;
    logic        w_alu_acc;
    logic [4:0]  w_head_rd;
    logic [31:0] w_head_data;
    logic [7:0]  w_ld_byte;
    logic [15:0] w_ld_half;
    logic [31:0] w_ld_aligned;
    logic [31:0] w_busy_next;
    logic [31:0] w_busy_masked;

    assign w_full      = (r_count == c_FIFO_FULL);
    assign w_empty     = (r_count == c_FIFO_EMPTY);
    assign w_head_rd   = r_fifo_rd[r_rd_ptr];
    assign w_head_data = r_fifo_data[r_rd_ptr];

    // Ready outputs are forced low while reset is held
    assign bus.ld_ready  = rst & ~w_full;
    assign bus.alu_ready = rst & w_empty;

    // Queued loads always win the write port; the ALU only gets it when empty
    assign w_push    = bus.ld_valid & bus.ld_ready;
    assign w_pop     = rst & ~w_empty;
    assign w_alu_acc = bus.alu_valid & bus.alu_ready;

    // Align and extend the returned memory word according to the load type
    always_comb begin
        w_ld_byte    = bus.ld_rdata[7:0];
        w_ld_half    = bus.ld_addr[1] ? bus.ld_rdata[31:16] : bus.ld_rdata[15:0];
        w_ld_aligned = bus.ld_rdata;
        case (bus.ld_addr)
            2'd0:    w_ld_byte = bus.ld_rdata[7:0];
            2'd1:    w_ld_byte = bus.ld_rdata[15:8];
            2'd2:    w_ld_byte = bus.ld_rdata[23:16];
            default: w_ld_byte = bus.ld_rdata[31:24];
        endcase
        case (bus.ld_funct3)
            3'b000:  w_ld_aligned = {{24{w_ld_byte[7]}}, w_ld_byte};
            3'b001:  w_ld_aligned = {{16{w_ld_half[15]}}, w_ld_half};
            3'b100:  w_ld_aligned = {24'd0, w_ld_byte};
            3'b101:  w_ld_aligned = {16'd0, w_ld_half};
            default: w_ld_aligned = bus.ld_rdata;
        endcase
    end

    // FIFO pointers and occupancy; push and pop in one cycle leave count as is
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_rd_ptr <= 1'b0;
            r_wr_ptr <= 1'b0;
            r_count  <= c_FIFO_EMPTY;
        end else begin
            if (w_push) begin
                r_wr_ptr <= ~r_wr_ptr;
            end
            if (w_pop) begin
                r_rd_ptr <= ~r_rd_ptr;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 2'd1;
                2'b01:   r_count <= r_count - 2'd1;
                default: r_count <= r_count;
            endcase
        end
    end

    // FIFO payload storage; contents are don't-care while the slot is free
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_fifo_rd[r_wr_ptr]   <= bus.ld_rd;
            r_fifo_data[r_wr_ptr] <= w_ld_aligned;
        end
    end

    // Registered write port; x0 targets update index/data but never write
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_wb_write <= 1'b0;
            r_wb_rd    <= 5'd0;
            r_wb_data  <= 32'd0;
        end else if (w_pop) begin
            r_wb_write <= (w_head_rd != 5'd0);
            r_wb_rd    <= w_head_rd;
            r_wb_data  <= w_head_data;
        end else if (w_alu_acc) begin
            r_wb_write <= (bus.alu_rd != 5'd0);
            r_wb_rd    <= bus.alu_rd;
            r_wb_data  <= bus.alu_data;
        end else begin
            r_wb_write <= 1'b0;
        end
    end

    // Next busy mask: clear on pop first so a same-index issue wins
    always_comb begin
        w_busy_next = r_busy;
        if (w_pop && (w_head_rd != 5'd0)) begin
            w_busy_next[w_head_rd] = 1'b0;
        end
        if (bus.ld_issue && (bus.ld_issue_rd != 5'd0)) begin
            w_busy_next[bus.ld_issue_rd] = 1'b1;
        end
    end

    // Outstanding-load mask register
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_busy <= 32'd0;
        end else begin
            r_busy <= w_busy_next;
        end
    end

    // x0 never reports as busy; hazard is silenced during reset
    assign w_busy_masked = {r_busy[31:1], 1'b0};
    assign bus.hazard    = rst & (w_busy_masked[bus.rs1] |
                                  w_busy_masked[bus.rs2] |
                                  w_busy_masked[bus.rd_q]);
    assign bus.busy      = r_busy;
    assign bus.wb_write  = r_wb_write;
    assign bus.wb_rd     = r_wb_rd;
    assign bus.wb_data   = r_wb_data;

endmodule
`default_nettype wire
